// File: rtl/cpu_irq_pkg.sv
// Shared constants and FSM state encoding for the CPU interrupt encode path.
package cpu_irq_pkg;

    localparam int NUM_IRQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_PRESENT = 1'b1
    } irq_state_e;

endpackage

// File: rtl/irq_prio_find.sv
// Combinational rotating priority search: lowest set bit of vec counting up from base, wrapping.
module irq_prio_find
    import cpu_irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [IDX_W-1:0]   base,
    output logic [IDX_W-1:0]   index,
    output logic               found
);

    logic [NUM_IRQ-1:0] rotated;
    logic [IDX_W-1:0]   offset;

    always_comb begin
        // Rotate right so that bit 'base' lands at position 0.
        rotated = NUM_IRQ'({vec, vec} >> base);
        offset  = '0;
        found   = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
                found  = 1'b1;
            end
        end
        index = offset + base;
    end

endmodule

// File: rtl/irq_encoder16.sv
// Registered 16-to-4 interrupt priority encoder with valid/ack handshake.
// Optional IRQ_ENCODER16_ROUND_ROBIN_EN rotates priority past the last acknowledged index.
module irq_encoder16
    import cpu_irq_pkg::*;
#(
    parameter int LEVEL_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  req,
    input  logic [NUM_IRQ-1:0]  mask,
    input  logic                irq_ack,
    output logic                irq_valid,
    output logic [IDX_W-1:0]    irq_index,
    output logic [NUM_IRQ-1:0]  pending
);

    // Handshake: irq_valid/irq_index stay stable until irq_ack is seen high on a rising edge
    // while irq_valid=1; that edge is the transfer. irq_ack with irq_valid=0 is ignored.

    irq_state_e          state, next_state;
    logic [IDX_W-1:0]    next_index;
    logic [NUM_IRQ-1:0]  req_q;
    logic [NUM_IRQ-1:0]  set_vec;
    logic [NUM_IRQ-1:0]  clr_vec;
    logic [NUM_IRQ-1:0]  eligible;
    logic [IDX_W-1:0]    base;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic                ack_fire;

    assign irq_valid = (state == IRQ_PRESENT);
    assign ack_fire  = irq_valid && irq_ack;
    assign set_vec   = (LEVEL_MODE != 0) ? req : (req & ~req_q);
    assign eligible  = pending & mask;

    always_comb begin
        clr_vec = '0;
        if (ack_fire) begin
            clr_vec[irq_index] = 1'b1;
        end
    end

`ifdef IRQ_ENCODER16_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx <= 4'hF;
        end else if (ack_fire) begin
            last_idx <= irq_index;
        end
    end

    assign base = last_idx + 4'd1;
`else
    assign base = '0;
`endif

    irq_prio_find u_prio_find (
        .vec   (eligible),
        .base  (base),
        .index (win_idx),
        .found (win_found)
    );

    // Set is ORed in after the clear so a same-cycle re-request survives the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending   <= '0;
            state     <= IRQ_IDLE;
            irq_index <= '0;
        end else begin
            req_q     <= req;
            pending   <= (pending & ~clr_vec) | set_vec;
            state     <= next_state;
            irq_index <= next_index;
        end
    end

    always_comb begin
        next_state = state;
        next_index = irq_index;
        case (state)
            IRQ_IDLE: begin
                if (win_found) begin
                    next_state = IRQ_PRESENT;
                    next_index = win_idx;
                end
            end
            IRQ_PRESENT: begin
                if (irq_ack) begin
                    next_state = IRQ_IDLE;
                end
            end
            default: next_state = IRQ_IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_encoder16.sv
// Self-checking bench for irq_encoder16: vector table plus hand sequences for multi-cycle corners.
module tb_irq_encoder16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req, mask, req_l;
    logic        irq_ack, ack_l;
    logic        valid, valid_l;
    logic [3:0]  index, index_l;
    logic [15:0] pending, pending_l;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] req;
        logic [15:0] mask;
        logic        ack;
        logic        exp_valid;
        logic [3:0]  exp_index;
        logic [15:0] exp_pending;
    } vec_t;

    vec_t vecs[$];

    irq_encoder16 #(.LEVEL_MODE(0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .irq_ack   (irq_ack),
        .irq_valid (valid),
        .irq_index (index),
        .pending   (pending)
    );

    irq_encoder16 #(.LEVEL_MODE(1)) u_dut_lvl (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_l),
        .mask      (mask),
        .irq_ack   (ack_l),
        .irq_valid (valid_l),
        .irq_index (index_l),
        .pending   (pending_l)
    );

    // Clock and reset helpers
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        req_l   = '0;
        irq_ack = 1'b0;
        ack_l   = 1'b0;
        mask    = 16'hFFFF;
        step();
        rst_n   = 1'b1;
    endtask

    // Scoreboard helpers
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic exp_v, input logic [3:0] exp_i,
                             input logic [15:0] exp_p);
        check({name, "_valid"}, {15'd0, valid}, {15'd0, exp_v});
        if (exp_v) check({name, "_index"}, {12'd0, index}, {12'd0, exp_i});
        check({name, "_pending"}, pending, exp_p);
    endtask

    function automatic void add(input string name, input logic rst, input logic [15:0] r,
                                input logic [15:0] m, input logic a, input logic ev,
                                input logic [3:0] ei, input logic [15:0] ep);
        vec_t v;
        v.name = name; v.rst = rst; v.req = r; v.mask = m; v.ack = a;
        v.exp_valid = ev; v.exp_index = ei; v.exp_pending = ep;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold;
        logic [3:0] exp_idx;

        rst_n = 1'b0; req = '0; req_l = '0; mask = 16'hFFFF; irq_ack = 1'b0; ack_l = 1'b0;
        step();
        check("reset_valid", {15'd0, valid}, 16'd0);
        check("reset_index", {12'd0, index}, 16'd0);
        check("reset_pending", pending, 16'h0000);
        step();
        rst_n = 1'b1;

        // Test 1: idle, plus ack while IDLE
        for (int i = 0; i < 5; i++) add("t1_idle", 0, 16'h0, 16'hFFFF, 0, 0, 0, 16'h0);
        add("t1_ack_idle", 0, 16'h0, 16'hFFFF, 1, 0, 0, 16'h0);
        // Test 2: single pulse on bit 5, long hold, mask dropped mid-present
        add("t2_e0", 0, 16'h0020, 16'hFFFF, 0, 0, 0, 16'h0020);
        add("t2_e1", 0, 16'h0000, 16'hFFFF, 0, 1, 5, 16'h0020);
        for (int i = 0; i < 10; i++)
            add("t2_hold", 0, 16'h0, (i == 4) ? 16'h0000 : 16'hFFFF, 0, 1, 5, 16'h0020);
        add("t2_ack", 0, 16'h0, 16'hFFFF, 1, 0, 0, 16'h0);
        add("t2_after", 0, 16'h0, 16'hFFFF, 0, 0, 0, 16'h0);
        // Test 3: bits 3, 9, 12 together
        add("t3_set", 1, 16'h1208, 16'hFFFF, 0, 0, 0, 16'h1208);
        add("t3_p3", 0, 16'h0, 16'hFFFF, 0, 1, 3, 16'h1208);
        add("t3_a3", 0, 16'h0, 16'hFFFF, 1, 0, 0, 16'h1200);
        add("t3_p9", 0, 16'h0, 16'hFFFF, 0, 1, 9, 16'h1200);
        add("t3_a9", 0, 16'h0, 16'hFFFF, 1, 0, 0, 16'h1000);
        add("t3_p12", 0, 16'h0, 16'hFFFF, 0, 1, 12, 16'h1000);
        add("t3_a12", 0, 16'h0, 16'hFFFF, 1, 0, 0, 16'h0000);
        add("t3_end", 0, 16'h0, 16'hFFFF, 0, 0, 0, 16'h0000);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            req     = vecs[k].req;
            mask    = vecs[k].mask;
            irq_ack = vecs[k].ack;
            step();
            check_out(vecs[k].name, vecs[k].exp_valid, vecs[k].exp_index, vecs[k].exp_pending);
        end
        irq_ack = 1'b0;

        // Test 4: masked pending bit presented once unmasked
        do_reset();
        mask = 16'hFFF7; req = 16'h0008;
        step(); check_out("t4_set", 0, 0, 16'h0008);
        req = 16'h0000;
        step(); check_out("t4_masked_a", 0, 0, 16'h0008);
        step(); check_out("t4_masked_b", 0, 0, 16'h0008);
        mask = 16'hFFFF;
        step(); check_out("t4_unmasked", 1, 3, 16'h0008);
        irq_ack = 1'b1;
        step(); check_out("t4_ack", 0, 0, 16'h0000);
        irq_ack = 1'b0;

        // Test 5: re-request in the same cycle as ack
        do_reset();
        req = 16'h0004;
        step(); check_out("t5_set", 0, 0, 16'h0004);
        req = 16'h0000;
        step(); check_out("t5_p2", 1, 2, 16'h0004);
        req = 16'h0004; irq_ack = 1'b1;
        step(); check_out("t5_ack_reset", 0, 0, 16'h0004);
        req = 16'h0000; irq_ack = 1'b0;
        step(); check_out("t5_repres", 1, 2, 16'h0004);
        irq_ack = 1'b1;
        step(); check_out("t5_ack2", 0, 0, 16'h0000);
        irq_ack = 1'b0;

        // Extreme bits 0 and 15 with variable ack delay
        do_reset();
        req = 16'h8001;
        step(); check_out("ext_set", 0, 0, 16'h8001);
        req = 16'h0000;
        step(); check_out("ext_p0", 1, 0, 16'h8001);
        hold = $urandom_range(0, 3);
        repeat (hold) begin step(); check_out("ext_hold0", 1, 0, 16'h8001); end
        irq_ack = 1'b1;
        step(); check_out("ext_a0", 0, 0, 16'h8000);
        irq_ack = 1'b0;
        step(); check_out("ext_p15", 1, 15, 16'h8000);
        hold = $urandom_range(0, 3);
        repeat (hold) begin step(); check_out("ext_hold15", 1, 15, 16'h8000); end
        irq_ack = 1'b1;
        step(); check_out("ext_a15", 0, 0, 16'h0000);
        irq_ack = 1'b0;

        // Test 6: level-mode instance, held req 0x0012, then reset mid-present
        do_reset();
`ifdef IRQ_ENCODER16_ROUND_ROBIN_EN
        exp_q = '{4'd1, 4'd4, 4'd1, 4'd4};
`else
        exp_q = '{4'd1, 4'd1, 4'd1, 4'd1};
`endif
        req_l = 16'h0012;
        step();
        check("t6_set_valid", {15'd0, valid_l}, 16'd0);
        check("t6_set_pending", pending_l, 16'h0012);
        step();
        for (int n = 0; n < 4; n++) begin
            exp_idx = exp_q.pop_front();
            check("t6_pres_valid", {15'd0, valid_l}, 16'd1);
            check("t6_pres_index", {12'd0, index_l}, {12'd0, exp_idx});
            ack_l = 1'b1;
            step();
            check("t6_ack_valid", {15'd0, valid_l}, 16'd0);
            check("t6_ack_pending", pending_l, 16'h0012);
            ack_l = 1'b0;
            step();
        end
        check("t6_queue_left", 16'(exp_q.size()), 16'd0);
        check("t6_pre_rst_valid", {15'd0, valid_l}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {15'd0, valid_l}, 16'd0);
        check("t6_rst_pending", pending_l, 16'h0000);
        req_l = 16'h0000;
        step();
        rst_n = 1'b1;
        step();
        check("t6_post_valid", {15'd0, valid_l}, 16'd0);
        check("t6_post_pending", pending_l, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
